// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU load/store path and a DMA master.
// Build option DMEM_ARB_STATS_EN adds saturating beat and stall statistics counters.
module dmem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int MAX_BURST    = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_last,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_dma_beats,
   output logic [15:0]       stat_cpu_stalls
`endif
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [BW-1:0] BURST_END  = BW'(MAX_BURST - 1);
   localparam logic [SW-1:0] STARVE_END = SW'(STARVE_LIMIT - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } state_t;

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] beat_cnt;

   logic dma_own;
   logic beat;
   logic read_beat;
   logic burst_done;
   logic grant_dma;

   assign dma_own    = (state == DMA_OWN);
   assign beat       = dma_own & dma_req;
   assign read_beat  = beat & ~dma_we;
   assign burst_done = beat & (dma_last | (beat_cnt == BURST_END));
   // CPU keeps the port unless it is idle or the DMA has waited long enough.
   assign grant_dma  = ~dma_own & dma_req & (~cpu_req | (starve_cnt == STARVE_END));

   assign dma_gnt   = dma_own;
   assign cpu_stall = dma_own & cpu_req;
   assign cpu_rdata = mem_rdata;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_req & cpu_we;
      mem_re    = cpu_req & ~cpu_we;
      if (dma_own) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_req & dma_we;
         mem_re    = dma_req & ~dma_we;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= CPU_OWN;
         starve_cnt <= '0;
         beat_cnt   <= '0;
         dma_rdata  <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         dma_rvalid <= read_beat;
         if (read_beat) dma_rdata <= mem_rdata;

         case (state)
            CPU_OWN: begin
               if (!dma_req)
                  starve_cnt <= '0;
               else if (cpu_req && starve_cnt != STARVE_MAX)
                  starve_cnt <= starve_cnt + SW'(1);
               if (grant_dma) state <= DMA_OWN;
            end
            DMA_OWN: begin
               if (beat) beat_cnt <= beat_cnt + BW'(1);
               // An idle master hands the port back immediately.
               if (burst_done || !dma_req) begin
                  state      <= CPU_OWN;
                  beat_cnt   <= '0;
                  starve_cnt <= '0;
               end
            end
            default: state <= CPU_OWN;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_dma_beats  <= '0;
         stat_cpu_stalls <= '0;
      end else begin
         if (beat && stat_dma_beats != 16'hFFFF)
            stat_dma_beats <= stat_dma_beats + 16'd1;
         if (cpu_stall && stat_cpu_stalls != 16'hFFFF)
            stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small combinational-read data memory model.
// Statistics checks are included when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_req, dma_we, dma_last;
   logic [15:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_gnt, dma_rvalid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_dma_beats, stat_cpu_stalls;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] tb_mem [0:255];

   dmem_arbiter #(
      .ADDR_W(16), .DATA_W(16), .MAX_BURST(8), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_dma_beats(stat_dma_beats), .stat_cpu_stalls(stat_cpu_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = tb_mem[mem_addr[7:0]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_last = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 16'hBEEF;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b exp 0", dma_gnt); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", dma_rvalid); end
      checks++; if (dma_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h exp 0000", dma_rdata); end
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL reset_mem_we: got %b exp 1", mem_we); end
      checks++; if (mem_addr !== 16'h0055) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0055", mem_addr); end
      checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL reset_mem_wdata: got %h exp beef", mem_wdata); end
      idle();
      reset = 1'b1;
      cycle();
   endtask

   task automatic test_dma_write();
      idle();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0010; dma_wdata = 16'h00A0;
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL wr_pre_gnt: got %b exp 0", dma_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_pre_mem_we: got %b exp 0", mem_we); end
      cycle();
      for (int i = 0; i < 4; i++) begin
         dma_addr  = 16'h0010 + 16'(i);
         dma_wdata = 16'h00A0 + 16'(i);
         dma_last  = (i == 3);
         #1;
         checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt[%0d]: got %b exp 1", i, dma_gnt); end
         checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we[%0d]: got %b exp 1", i, mem_we); end
         checks++; if (mem_addr !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL wr_mem_addr[%0d]: got %h exp %h", i, mem_addr, 16'h0010 + 16'(i)); end
         cycle();
      end
      idle();
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL wr_release_gnt: got %b exp 0", dma_gnt); end
      for (int i = 0; i < 4; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010 + 16'(i);
         #1;
         checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rd_mem_re[%0d]: got %b exp 1", i, mem_re); end
         checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_stall[%0d]: got %b exp 0", i, cpu_stall); end
         checks++; if (cpu_rdata !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL rd_data[%0d]: got %h exp %h", i, cpu_rdata, 16'h00A0 + 16'(i)); end
         cycle();
      end
      idle();
   endtask

   task automatic test_starvation();
      idle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0030; dma_wdata = 16'h5555; dma_last = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL starve_gnt[%0d]: got %b exp 0", c, dma_gnt); end
         checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_stall[%0d]: got %b exp 0", c, cpu_stall); end
         checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL starve_cpu_addr[%0d]: got %h exp 0010", c, mem_addr); end
         cycle();
      end
      #1;
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL starve_forced_gnt: got %b exp 1", dma_gnt); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL starve_forced_stall: got %b exp 1", cpu_stall); end
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL starve_mem_we: got %b exp 1", mem_we); end
      checks++; if (mem_addr !== 16'h0030) begin errors++; $display("FAIL starve_dma_addr: got %h exp 0030", mem_addr); end
      cycle();
      dma_req = 1'b0; dma_last = 1'b0;
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL starve_back_gnt: got %b exp 0", dma_gnt); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_back_stall: got %b exp 0", cpu_stall); end
`ifdef DMEM_ARB_STATS_EN
      checks++; if (stat_dma_beats !== 16'd5) begin errors++; $display("FAIL stat_beats: got %0d exp 5", stat_dma_beats); end
      checks++; if (stat_cpu_stalls !== 16'd1) begin errors++; $display("FAIL stat_stalls: got %0d exp 1", stat_cpu_stalls); end
`endif
      cycle();
      idle();
   endtask

   task automatic test_max_burst();
      idle();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 16'h00B0;
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL burst_pre_gnt: got %b exp 0", dma_gnt); end
      cycle();
      for (int i = 0; i < 8; i++) begin
         dma_addr  = 16'h0040 + 16'(i);
         dma_wdata = 16'h00B0 + 16'(i);
         #1;
         checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL burst_gnt[%0d]: got %b exp 1", i, dma_gnt); end
         cycle();
      end
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL burst_gap_gnt: got %b exp 0", dma_gnt); end
      cycle();
      dma_req = 1'b0;
      #1;
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL burst_regrant: got %b exp 1", dma_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL burst_idle_mem_we: got %b exp 0", mem_we); end
      cycle();
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL burst_idle_release: got %b exp 0", dma_gnt); end
      idle();
      cpu_req = 1'b1; cpu_addr = 16'h0047;
      #1;
      checks++; if (cpu_rdata !== 16'h00B7) begin errors++; $display("FAIL burst_last_data: got %h exp 00b7", cpu_rdata); end
      cycle();
      idle();
   endtask

   task automatic test_dma_read();
      idle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
      cycle();
      idle();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020; dma_last = 1'b1;
      #1;
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL dread_pre_rvalid: got %b exp 0", dma_rvalid); end
      cycle();
      #1;
      checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL dread_mem_re: got %b exp 1", mem_re); end
      cycle();
      idle();
      #1;
      checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL dread_rvalid: got %b exp 1", dma_rvalid); end
      checks++; if (dma_rdata !== 16'h1234) begin errors++; $display("FAIL dread_rdata: got %h exp 1234", dma_rdata); end
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL dread_gnt: got %b exp 0", dma_gnt); end
      cycle();
      #1;
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL dread_rvalid_drop: got %b exp 0", dma_rvalid); end
      checks++; if (dma_rdata !== 16'h1234) begin errors++; $display("FAIL dread_rdata_hold: got %h exp 1234", dma_rdata); end
   endtask

   task automatic test_reset_mid_burst();
      idle();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
      cycle();
      cycle();
      cycle();
      #1;
      checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_rvalid: got %b exp 1", dma_rvalid); end
      checks++; if (dut.beat_cnt !== 4'd2) begin errors++; $display("FAIL mid_pre_beat_cnt: got %0d exp 2", dut.beat_cnt); end
      cpu_req = 1'b1;
      reset   = 1'b0;
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL mid_gnt: got %b exp 0", dma_gnt); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b exp 0", cpu_stall); end
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b exp 0", dma_rvalid); end
      checks++; if (dut.beat_cnt !== 4'd0) begin errors++; $display("FAIL mid_beat_cnt: got %0d exp 0", dut.beat_cnt); end
      checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL mid_cpu_path: got %b exp 1", mem_re); end
`ifdef DMEM_ARB_STATS_EN
      checks++; if (stat_dma_beats !== 16'd0) begin errors++; $display("FAIL mid_stat_beats: got %0d exp 0", stat_dma_beats); end
      checks++; if (stat_cpu_stalls !== 16'd0) begin errors++; $display("FAIL mid_stat_stalls: got %0d exp 0", stat_cpu_stalls); end
`endif
      cycle();
      idle();
      reset = 1'b1;
      #1;
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL mid_after_gnt: got %b exp 0", dma_gnt); end
      cycle();
   endtask

   initial begin
      for (int a = 0; a < 256; a++) tb_mem[a] = '0;
      test_reset();
      test_dma_write();
      test_starvation();
      test_max_burst();
      test_dma_read();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
